// File: rtl/pic_irq.sv
// Purpose: fixed-priority 8-level interrupt controller (IRR/IMR/ISR) downstream of the i8253 timer.
// Latency: request edge -> IRR one clock, IRR -> intr one clock; vector registered on inta; reads combinational.
// Backpressure: none; the register bus and inta are single-cycle strobes that are always accepted.
//
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   a, wr, rd, din   2-bit register bus: a=0 cmd/IRR, a=1 IMR, a=2 BASE/ISR, a=3 TRIG/poll
//   dout             combinational read data, 0 when rd=0
//   irq_in           request lines, [2:0] from timer out[2:0], all synchronous to clk
//   inta             one-cycle interrupt acknowledge from the CPU
//   intr             registered interrupt request to the CPU
//   vector           {BASE, level} captured at the last inta (level 7 on a spurious ack)
`timescale 1ns/1ps

module pic_irq (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] irq_in,
    input  logic       inta,
    output logic       intr,
    output logic [7:0] vector
);

    localparam logic [2:0] OP_NS_EOI = 3'b001;
    localparam logic [2:0] OP_SP_EOI = 3'b011;

    logic [7:0] irr;
    logic [7:0] imr;
    logic [7:0] isr;
    logic [7:0] trig;
    logic [7:0] prev;
    logic [4:0] base;

    // ------------------------------------------------------------------
    // Arbitration: lowest-index unmasked pending request wins.
    // ------------------------------------------------------------------
    logic [7:0] req;
    logic       win_vld;
    logic [2:0] win_idx;

    always_comb begin
        req     = irr & ~imr;
        win_vld = 1'b0;
        win_idx = 3'd7;
        // Scan from the lowest priority upward so the last hit is the highest priority.
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    // Any in-service level at or above the winner's priority blocks it.
    logic [7:0] blk_mask;
    logic       win_elig;

    always_comb begin
        blk_mask = '0;
        for (int i = 0; i < 8; i++) begin
            blk_mask[i] = (i <= int'(win_idx));
        end
    end

    assign win_elig = win_vld && ((isr & blk_mask) == 8'h00);

    // ------------------------------------------------------------------
    // Register-bus command decode
    // ------------------------------------------------------------------
    logic wr_cmd;
    logic wr_imr;
    logic wr_base;
    logic wr_trig;
    logic eoi_ns;
    logic eoi_sp;

    assign wr_cmd  = wr && (a == 2'd0);
    assign wr_imr  = wr && (a == 2'd1);
    assign wr_base = wr && (a == 2'd2);
    assign wr_trig = wr && (a == 2'd3);
    assign eoi_ns  = wr_cmd && (din[7:5] == OP_NS_EOI);
    assign eoi_sp  = wr_cmd && (din[7:5] == OP_SP_EOI);

    // ------------------------------------------------------------------
    // ISR next state: EOI clears against the old ISR, then the ack set is
    // ORed in so a set on the same bit wins over the clear.
    // ------------------------------------------------------------------
    logic [7:0] isr_low;
    logic [7:0] eoi_clr;
    logic [7:0] ack_set;
    logic [7:0] isr_nxt;

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        isr_low = isr & (~isr + 8'd1);
        eoi_clr = 8'h00;
        if (eoi_ns) begin
            eoi_clr = isr_low;
        end else if (eoi_sp) begin
            eoi_clr = 8'd1 << din[2:0];
        end
        ack_set = (inta && win_elig) ? (8'd1 << win_idx) : 8'h00;
        isr_nxt = (isr & ~eoi_clr) | ack_set;
    end

    // ------------------------------------------------------------------
    // IRR next state. Level bits track the pin; edge bits set on a rising
    // edge and clear only on the ack that selects them, set winning a tie.
    // ------------------------------------------------------------------
    logic [7:0] edge_set;
    logic [7:0] irr_edge;
    logic [7:0] irr_nxt;

    always_comb begin
        edge_set = irq_in & ~prev;
        irr_edge = edge_set | (irr & ~ack_set);
        irr_nxt  = (trig & irq_in) | (~trig & irr_edge);
    end

    // ------------------------------------------------------------------
    // Vector for this ack: winner if eligible, otherwise spurious level 7.
    // ------------------------------------------------------------------
    logic [7:0] ack_vec;

    assign ack_vec = win_elig ? {base, win_idx} : {base, 3'd7};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr    <= 8'h00;
            imr    <= 8'hFF;
            isr    <= 8'h00;
            trig   <= 8'h00;
            prev   <= 8'h00;
            base   <= 5'd0;
            intr   <= 1'b0;
            vector <= 8'h00;
        end else begin
            irr  <= irr_nxt;
            isr  <= isr_nxt;
            prev <= irq_in;
            // intr reflects the arbitration on this cycle's state, before the ack lands.
            intr <= win_elig;
            if (inta) begin
                vector <= ack_vec;
            end
            if (wr_imr) begin
                imr <= din;
            end
            if (wr_base) begin
                base <= din[7:3];
            end
            if (wr_trig) begin
                trig <= din;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux, side-effect free. Poll reports the winner regardless of ISR.
    // ------------------------------------------------------------------
    always_comb begin
        dout = 8'h00;
        if (rd) begin
            case (a)
                2'd0:    dout = irr;
                2'd1:    dout = imr;
                2'd2:    dout = isr;
                default: dout = {base, win_idx};
            endcase
        end
    end

endmodule

// File: tb/tb_pic_irq.sv
`timescale 1ns/1ps

module tb_pic_irq;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [1:0] a      = 2'd0;
    logic       wr     = 1'b0;
    logic       rd     = 1'b0;
    logic [7:0] din    = 8'h00;
    logic [7:0] irq_in = 8'h00;
    logic       inta   = 1'b0;
    logic [7:0] dout;
    logic       intr;
    logic [7:0] vector;

    int n_checks = 0;
    int n_fail   = 0;

    pic_irq dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .wr     (wr),
        .rd     (rd),
        .din    (din),
        .dout   (dout),
        .irq_in (irq_in),
        .inta   (inta),
        .intr   (intr),
        .vector (vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-level bookkeeping with plain loops.
    // ------------------------------------------------------------------
    bit [7:0] m_irr  = 8'h00;
    bit [7:0] m_imr  = 8'hFF;
    bit [7:0] m_isr  = 8'h00;
    bit [7:0] m_trig = 8'h00;
    bit [7:0] m_prev = 8'h00;
    bit [7:0] m_vec  = 8'h00;
    bit [4:0] m_base = 5'd0;
    bit       m_intr = 1'b0;

    function automatic int m_winner();
        for (int i = 0; i < 8; i++) begin
            if (m_irr[i] && !m_imr[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_eligible(input int w);
        if (w < 0) return 1'b0;
        for (int i = 0; i <= w; i++) begin
            if (m_isr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] addr);
        int w;
        w = m_winner();
        case (addr)
            2'd0:    return m_irr;
            2'd1:    return m_imr;
            2'd2:    return m_isr;
            default: return {m_base, (w < 0) ? 3'd7 : 3'(w)};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin : model_upd
        int w;
        bit el;
        bit [7:0] nirr;
        bit [7:0] nisr;
        if (reset) begin
            m_irr  = 8'h00;
            m_imr  = 8'hFF;
            m_isr  = 8'h00;
            m_trig = 8'h00;
            m_prev = 8'h00;
            m_vec  = 8'h00;
            m_base = 5'd0;
            m_intr = 1'b0;
        end else begin
            w    = m_winner();
            el   = m_eligible(w);
            nisr = m_isr;
            nirr = m_irr;
            if (wr && a == 2'd0) begin
                if (din[7:5] == 3'b001) begin
                    for (int j = 0; j < 8; j++) begin
                        if (nisr[j]) begin
                            nisr[j] = 1'b0;
                            break;
                        end
                    end
                end else if (din[7:5] == 3'b011) begin
                    nisr[din[2:0]] = 1'b0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (m_trig[i])                    nirr[i] = irq_in[i];
                else if (irq_in[i] && !m_prev[i]) nirr[i] = 1'b1;
                else if (inta && el && w == i)    nirr[i] = 1'b0;
            end
            if (inta) begin
                if (el) begin
                    nisr[w] = 1'b1;
                    m_vec   = {m_base, 3'(w)};
                end else begin
                    m_vec   = {m_base, 3'd7};
                end
            end
            if (wr && a == 2'd1) m_imr  = din;
            if (wr && a == 2'd2) m_base = din[7:3];
            if (wr && a == 2'd3) m_trig = din;
            m_prev = irq_in;
            m_intr = el;
            m_irr  = nirr;
            m_isr  = nisr;
        end
    end

    // Every cycle: outputs against the model, plus any read in progress.
    always @(negedge clk) begin
        check("intr_vs_model", {7'd0, intr}, {7'd0, m_intr});
        check("vector_vs_model", vector, m_vec);
        if (rd) check("dout_vs_model", dout, m_read(a));
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [1:0] ad, input logic [7:0] d);
        a   = ad;
        din = d;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
    endtask

    task automatic rchk(input string nm, input logic [1:0] ad, input logic [7:0] exp);
        a  = ad;
        rd = 1'b1;
        #1;
        check(nm, dout, exp);
        rd = 1'b0;
    endtask

    task automatic ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_in = m;
        tick();
        irq_in = 8'h00;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_intr", {7'd0, intr}, 8'h00);
        check("rst_vector", vector, 8'h00);
        rchk("rst_imr", 2'd1, 8'hFF);
        rchk("rst_poll", 2'd3, 8'h07);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic request on level 1
        wreg(2'd1, 8'hF8);
        wreg(2'd2, 8'h40);
        pulse(8'h02);
        check("l1_intr_k", {7'd0, intr}, 8'h00);
        tick();
        check("l1_intr_k1", {7'd0, intr}, 8'h01);
        rchk("l1_irr", 2'd0, 8'h02);
        rchk("l1_poll", 2'd3, 8'h41);
        ack();
        check("l1_vector", vector, 8'h41);
        rchk("l1_isr", 2'd2, 8'h02);
        tick();
        check("l1_intr_drop", {7'd0, intr}, 8'h00);

        // Nesting: ISR[2] in service, then levels 0 and 5
        wreg(2'd0, 8'h61);
        wreg(2'd1, 8'h00);
        pulse(8'h04);
        tick();
        ack();
        check("l2_vector", vector, 8'h42);
        pulse(8'h21);
        tick();
        check("l0_intr", {7'd0, intr}, 8'h01);
        ack();
        check("l0_vector", vector, 8'h40);
        tick();
        tick();
        check("l5_blocked", {7'd0, intr}, 8'h00);
        rchk("l5_irr", 2'd0, 8'h20);
        wreg(2'd0, 8'h20);
        rchk("eoi1_isr", 2'd2, 8'h04);
        tick();
        tick();
        check("l5_still_blocked", {7'd0, intr}, 8'h00);
        wreg(2'd0, 8'h20);
        check("eoi2_intr_e", {7'd0, intr}, 8'h00);
        tick();
        check("l5_intr_e1", {7'd0, intr}, 8'h01);
        ack();
        check("l5_vector", vector, 8'h45);
        rchk("l5_isr", 2'd2, 8'h20);
        wreg(2'd0, 8'h20);
        tick();

        // Spurious acknowledge
        wreg(2'd2, 8'h80);
        ack();
        check("spur_vector", vector, 8'h87);
        rchk("spur_isr", 2'd2, 8'h00);

        // Level mode on bit 3
        wreg(2'd3, 8'h08);
        irq_in = 8'h08;
        tick();
        tick();
        check("lv_intr", {7'd0, intr}, 8'h01);
        ack();
        check("lv_vector", vector, 8'h83);
        rchk("lv_irr_kept", 2'd0, 8'h08);
        tick();
        tick();
        check("lv_blocked", {7'd0, intr}, 8'h00);
        wreg(2'd0, 8'h63);
        tick();
        check("lv_reassert", {7'd0, intr}, 8'h01);
        irq_in = 8'h00;
        tick();
        rchk("lv_irr_drop", 2'd0, 8'h00);
        tick();
        tick();
        check("lv_intr_off", {7'd0, intr}, 8'h00);
        wreg(2'd3, 8'h00);

        // Edge on bit 4 coincident with the ack selecting level 4
        pulse(8'h10);
        tick();
        check("e4_intr", {7'd0, intr}, 8'h01);
        irq_in = 8'h10;
        inta   = 1'b1;
        tick();
        irq_in = 8'h00;
        inta   = 1'b0;
        check("e4_vector", vector, 8'h84);
        rchk("e4_isr", 2'd2, 8'h10);
        rchk("e4_irr_kept", 2'd0, 8'h10);

        // Reset while intr is high and ISR=8'h10
        pulse(8'h02);
        tick();
        check("pre_rst_intr", {7'd0, intr}, 8'h01);
        #1 reset = 1'b1;
        #1;
        check("arst_intr", {7'd0, intr}, 8'h00);
        check("arst_vector", vector, 8'h00);
        rchk("arst_isr", 2'd2, 8'h00);
        tick();
        rchk("arst_imr", 2'd1, 8'hFF);
        rchk("arst_irr", 2'd0, 8'h00);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_intr", {7'd0, intr}, 8'h00);
        rchk("post_rst_imr", 2'd1, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pic_irq.md
# pic_irq

Fixed-priority 8-level interrupt controller sitting directly downstream of the i8253 timer. It latches requests from the timer's `out[2:0]` outputs and up to five other sources. It arbitrates them against a mask and an in-service register, raises `intr` to the CPU, and returns a vector on a single-cycle acknowledge. The CPU programs and inspects it through the same 2-bit-address register bus as the timer.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  i/o clock, the same clock that drives the timer.
- `reset`  in  1  asynchronous, active-high reset.
- `a`  in  2  register address.
- `wr`  in  1  register write strobe, sampled at the `clk` rising edge.
- `rd`  in  1  register read enable.
- `din`  in  8  write data.
- `dout`  out  8  read data. Combinational; 0 when `rd`=0.
- `irq_in`  in  8  request lines.
  - Bits [2:0] connect to timer `out[2:0]`.
  - All bits are synchronous to `clk`.
- `inta`  in  1  interrupt acknowledge, a one-cycle pulse from the CPU.
- `intr`  out  1  interrupt request to the CPU. Registered.
- `vector`  out  8  vector captured at the last `inta`. Registered.

## Operation
Registers:
- IRR[7:0]: pending requests.
- IMR[7:0]: mask; 1 = masked.
- ISR[7:0]: in service.
- TRIG[7:0]: trigger mode; 1 = level, 0 = rising edge.
- BASE[4:0]: vector base.
- PREV[7:0]: `irq_in` delayed one cycle.

Register writes (`wr`=1):
- `a`=0, command decoded from `din[7:5]`:
  - 3'b001: non-specific EOI; clears the lowest-index set ISR bit.
  - 3'b011: specific EOI; clears ISR[`din[2:0]`].
  - All other opcodes are ignored.
- `a`=1: IMR <= `din`.
- `a`=2: BASE <= `din[7:3]`; `din[2:0]` is ignored.
- `a`=3: TRIG <= `din`.

Register reads (`rd`=1), with no side effects:
- `a`=0: IRR.
- `a`=1: IMR.
- `a`=2: ISR.
- `a`=3: poll, {BASE, n} where n is the current winner. Returns {BASE, 3'd7} if there is no winner.

Request capture, per bit i, every cycle:
- Edge mode: IRR[i] is set when `irq_in[i]` & ~PREV[i]. It is cleared only by `inta` selecting level i. If the set and the clear happen in the same cycle, set wins.
- Level mode: IRR[i] <= `irq_in[i]`. `inta` does not clear it.

Arbitration:
- Fixed priority; bit 0 is highest.
- Winner n = lowest index with IRR[n] & ~IMR[n].
- The winner is eligible only if no ISR bit with index <= n is set. Equal or higher priority in service blocks it.

`intr`:
- `intr` <= eligible winner exists, registered every cycle.

`inta` cycle:
- With an eligible winner n:
  - ISR[n] is set.
  - IRR[n] is cleared if TRIG[n]=0.
  - `vector` <= {BASE, n}.
- With no eligible winner (spurious acknowledge):
  - `vector` <= {BASE, 3'd7}.
  - ISR and IRR are unchanged.

Simultaneous events:
- EOI and `inta` in the same cycle: EOI is evaluated on the old ISR. The `inta` set is then ORed in; if both touch the same bit, set wins.
- IMR, TRIG or BASE write in the same cycle as `inta`: arbitration and `vector` use the old values. New values take effect the next cycle.

Reset (asynchronous, applies to all state):
- IRR=0, ISR=0, PREV=0, TRIG=0, BASE=0.
- IMR=8'hFF, so all levels are masked.
- `intr`=0, `vector`=0.
- `dout` follows the rule above.
- Reset asserted mid-operation clears pending and in-service state immediately. No `intr` glitch is permitted after release.

## Timing
- Edge k: `irq_in[i]` rises and is sampled; IRR[i]=1 after edge k.
- Edge k+1: `intr`=1. Latency from request to `intr` is 2 clocks.
- Edge m: `inta` is sampled; ISR, IRR and `vector` are updated after edge m. `vector` is stable from edge m until the next `inta`.
- Edge m+1: `intr` is re-evaluated against the new ISR. It drops unless a higher-priority request is eligible.
- EOI write at edge e: ISR is updated after edge e. A blocked lower request raises `intr` after edge e+1.
- `dout` is combinational from `a`, `rd` and the current registers. There is no read latency.
- A level held high in edge mode produces exactly one request.

## Test plan
- Reset, then write IMR=8'hF8 and BASE=8'h40. Pulse `irq_in[1]` at edge k.
  - `intr`=1 after edge k+1.
  - Pulse `inta`: `vector`=8'h41 and ISR=8'h02. `intr`=0 one cycle later.
- Set ISR[2] via `inta`, then raise `irq_in[0]` and `irq_in[5]` (IMR=0).
  - `intr` rises; `inta` gives `vector`={BASE,0}.
  - Non-specific EOI clears bit 0; a second non-specific EOI clears bit 2.
  - Only then does level 5 raise `intr`.
- Pulse `inta` with nothing pending and BASE=8'h80: `vector`=8'h87, ISR unchanged.
- Level mode on bit 3 (TRIG=8'h08), `irq_in[3]` held high:
  - IRR[3] stays 1 after `inta`.
  - After specific EOI 3, `intr` re-asserts within 2 cycles.
  - Dropping `irq_in[3]` clears IRR[3] next cycle.
- Edge arrives on bit 4 in the same cycle as the `inta` selecting level 4: IRR[4] remains 1 afterwards.
- Assert `reset` while `intr`=1 and ISR=8'h10:
  - Immediately `intr`=0, ISR=0, IMR=8'hFF.
  - Read `a`=1 returns 8'hFF.
